// File: rtl/execute_stage_fwd.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative multiplier and EX/MEM register.
// ALU ops reach M one edge after E; MUL holds E for XLEN+2 cycles and raises BusyE to stall F/D/E.
module execute_stage_fwd #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      BranchOpE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulState_t;

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic [SHW-1:0]  shamt;
  logic            taken;
  logic            isMul;
  logic            mulStart;

  mulState_t       state;
  mulState_t       stateNext;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;

  // Forwarding: 00 and 11 both select the register file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUResultM;
      default: srcA = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwdB = ResultW;
      2'b10:   fwdB = ALUResultM;
      default: fwdB = RD2E;
    endcase
  end

  assign srcB  = ALUSrcE ? ImmExtE : fwdB;
  assign shamt = srcB[SHW-1:0];

  // MUL (code 10) yields 0 here; the product comes from the multiplier in DONE.
  always_comb begin
    case (ALUControlE)
      4'd0:    aluResult = srcA + srcB;
      4'd1:    aluResult = srcA - srcB;
      4'd2:    aluResult = srcA & srcB;
      4'd3:    aluResult = srcA | srcB;
      4'd4:    aluResult = srcA ^ srcB;
      4'd5:    aluResult = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'd6:    aluResult = {{(XLEN-1){1'b0}}, srcA < srcB};
      4'd7:    aluResult = srcA << shamt;
      4'd8:    aluResult = srcA >> shamt;
      4'd9:    aluResult = $unsigned($signed(srcA) >>> shamt);
      default: aluResult = '0;
    endcase
  end

  // Branch compare sees the forwarded rs2 value, never the immediate.
  always_comb begin
    case (BranchOpE)
      3'b000:  taken = (srcA == fwdB);
      3'b001:  taken = (srcA != fwdB);
      3'b100:  taken = ($signed(srcA) < $signed(fwdB));
      3'b101:  taken = ($signed(srcA) >= $signed(fwdB));
      3'b110:  taken = (srcA < fwdB);
      3'b111:  taken = (srcA >= fwdB);
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE    = !FlushE && (JumpE || (BranchE && taken));
  assign PCTargetE = PCE + ImmExtE;

  assign isMul    = (ALUControlE == 4'd10);
  assign mulStart = MUL_EN && (state == IDLE) && isMul && !FlushE;
  assign BusyE    = MUL_EN && !FlushE && (((state == IDLE) && isMul) || (state == RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (FlushE) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (mulStart) stateNext = RUN;
        RUN:     if (cnt == SHW'(XLEN-1)) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Shift-and-add: one multiplier bit per RUN cycle, operands frozen at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mulStart) begin
      mcand  <= srcA;
      mplier <= srcB;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (FlushE || BusyE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      // E inputs are held through the multiply, so DONE pairs the product with its own controls.
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= (state == DONE) ? acc : aluResult;
      WriteDataM <= fwdB;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage_fwd.sv
// Bench for execute_stage_fwd: vector table for single-cycle ops, hand sequences for MUL, flush and reset.
module tb_execute_stage_fwd;

  localparam int NV = 23;

  logic        clk;
  logic        rst;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, FlushE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  BranchOpE;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, resW;
    logic        aluSrc;
    logic [1:0]  fA, fB;
    logic        br, jmp;
    logic [2:0]  brOp;
    logic        flush;
    logic        expPcSrc;
    logic [31:0] expTgt, expAlu, expWd;
  } vec_t;

  typedef struct {
    logic        regWrite, memWrite;
    logic [1:0]  resultSrc;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } mExp_t;

  vec_t  vecs [NV];
  mExp_t sb[$];
  int    tests = 0;
  int    fails = 0;

  execute_stage_fwd #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .BranchOpE(BranchOpE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic checkM(input mExp_t e, input string tag);
    chk({tag, "_alu"}, ALUResultM, e.alu);
    chk({tag, "_wd"}, WriteDataM, e.wd);
    chk({tag, "_rd"}, 32'(RdM), 32'(e.rd));
    chk({tag, "_ctrl"}, 32'({RegWriteM, MemWriteM, ResultSrcM}),
        32'({e.regWrite, e.memWrite, e.resultSrc}));
    chk({tag, "_pc4"}, PCPlus4M, e.pc4);
  endtask

  task automatic popCheck(input string tag);
    mExp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_sb: got empty scoreboard, expected a pending entry", tag);
    end else begin
      e = sb.pop_front();
      checkM(e, tag);
    end
  endtask

  function automatic mExp_t bubble();
    mExp_t e;
    e.regWrite = 1'b0; e.memWrite = 1'b0; e.resultSrc = 2'd0; e.rd = 5'd0;
    e.alu = 32'd0; e.wd = 32'd0; e.pc4 = 32'd0;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [31:0] resW, input logic aluSrc,
                               input logic [1:0] fA, input logic [1:0] fB, input logic br,
                               input logic jmp, input logic [2:0] brOp, input logic flush,
                               input logic expPcSrc, input logic [31:0] expTgt,
                               input logic [31:0] expAlu, input logic [31:0] expWd);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resW = resW; v.aluSrc = aluSrc;
    v.fA = fA; v.fB = fB; v.br = br; v.jmp = jmp; v.brOp = brOp; v.flush = flush;
    v.expPcSrc = expPcSrc; v.expTgt = expTgt; v.expAlu = expAlu; v.expWd = expWd;
    return v;
  endfunction

  task automatic applyVec(input vec_t v, input int i);
    mExp_t e;
    logic [31:0] idx;
    idx = 32'(i);
    ALUControlE = v.op; RD1E = v.rd1; RD2E = v.rd2; ImmExtE = v.imm; ResultW = v.resW;
    ALUSrcE = v.aluSrc; ForwardAE = v.fA; ForwardBE = v.fB; BranchE = v.br; JumpE = v.jmp;
    BranchOpE = v.brOp; FlushE = v.flush; PCE = 32'h40; PCPlus4E = 32'h100 + 4 * idx;
    RdE = 5'(idx + 1); RegWriteE = 1'b1; MemWriteE = idx[0]; ResultSrcE = idx[1:0];
    if (v.flush) e = bubble();
    else begin
      e.regWrite = 1'b1; e.memWrite = idx[0]; e.resultSrc = idx[1:0]; e.rd = 5'(idx + 1);
      e.alu = v.expAlu; e.wd = v.expWd; e.pc4 = 32'h100 + 4 * idx;
    end
    sb.push_back(e);
  endtask

  task automatic driveOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    ALUControlE = op; RD1E = a; RD2E = b; ImmExtE = 32'd0; ResultW = 32'd0; ALUSrcE = 1'b0;
    ForwardAE = 2'd0; ForwardBE = 2'd0; BranchE = 1'b0; JumpE = 1'b0; BranchOpE = 3'd0;
    FlushE = 1'b0; PCE = 32'h40; PCPlus4E = 32'h200; RdE = rd; RegWriteE = 1'b1;
    MemWriteE = 1'b0; ResultSrcE = 2'd1;
  endtask

  function automatic mExp_t opExp(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] b);
    mExp_t e;
    e.regWrite = 1'b1; e.memWrite = 1'b0; e.resultSrc = 2'd1; e.rd = rd;
    e.alu = res; e.wd = b; e.pc4 = 32'h200;
    return e;
  endfunction

  // Drives a MUL at #1 after an edge, holds it through DONE, checks busy length, bubbles, product.
  task automatic doMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] prod, input string tag);
    int busyCnt;
    logic bubbleOk;
    driveOp(4'd10, a, b, rd);
    sb.push_back(opExp(rd, prod, b));
    #1;
    chk({tag, "_start_busy"}, 32'(BusyE), 32'd1);
    busyCnt = 0;
    bubbleOk = 1'b1;
    while (BusyE && busyCnt < 100) begin
      busyCnt++;
      @(posedge clk); #1;
      if (ALUResultM != 0 || RegWriteM || RdM != 0 || WriteDataM != 0) bubbleOk = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 32'(busyCnt), 32'd33);
    chk({tag, "_bubbles"}, 32'(bubbleOk), 32'd1);
    @(posedge clk); #1;
    popCheck(tag);
  endtask

  initial begin
    rst = 1'b1;
    driveOp(4'd0, 32'd0, 32'd0, 5'd0);
    RegWriteE = 1'b0;
    ResultSrcE = 2'd0;
    PCPlus4E = 32'd0;

    vecs[0]  = mkv(4'd0, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'd5, 32'd3);
    vecs[1]  = mkv(4'd0, 32'h999, 32'd7, 32'd0, 32'd0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'd12, 32'd7);
    vecs[2]  = mkv(4'd0, 32'h100, 32'h55, 32'd8, 32'hDEAD, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h48, 32'h108, 32'hDEAD);
    vecs[3]  = mkv(4'd1, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'hFFFFFFFE, 32'd5);
    vecs[4]  = mkv(4'd2, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'hF000, 32'hFF00);
    vecs[5]  = mkv(4'd3, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'hFFF0, 32'hFF00);
    vecs[6]  = mkv(4'd4, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'h0FF0, 32'hFF00);
    vecs[7]  = mkv(4'd5, 32'hFFFFFFFF, 32'd1, 32'h20, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 32'h60, 32'd1, 32'd1);
    vecs[8]  = mkv(4'd6, 32'hFFFFFFFF, 32'd1, 32'h20, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 32'h60, 32'd0, 32'd1);
    vecs[9]  = mkv(4'd7, 32'd1, 32'h23, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'd8, 32'h23);
    vecs[10] = mkv(4'd8, 32'h80000000, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'h08000000, 32'd4);
    vecs[11] = mkv(4'd9, 32'h80000000, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'hF8000000, 32'd4);
    vecs[12] = mkv(4'd0, 32'd7, 32'd7, 32'hFFFFFFF8, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h38, 32'd14, 32'd7);
    vecs[13] = mkv(4'd0, 32'd7, 32'd7, 32'hFFFFFFF8, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h38, 32'd14, 32'd7);
    vecs[14] = mkv(4'd0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 32'h50, 32'd0, 32'd1);
    vecs[15] = mkv(4'd0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 32'h50, 32'd0, 32'd1);
    vecs[16] = mkv(4'd0, 32'd1, 32'd1, 32'd4, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h44, 32'd0, 32'd0);
    vecs[17] = mkv(4'd0, 32'd1, 32'd1, 32'd4, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'h44, 32'd2, 32'd1);
    vecs[18] = mkv(4'd12, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'd0, 32'd6);
    vecs[19] = mkv(4'd0, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 32'h40, 32'd8, 32'd4);
    vecs[20] = mkv(4'd0, 32'd7, 32'd7, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h40, 32'd0, 32'd0);
    vecs[21] = mkv(4'd1, 32'h123, 32'd1, 32'd0, 32'h10, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'hF, 32'd1);
    vecs[22] = mkv(4'd0, 32'd5, 32'd5, 32'd8, 32'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h48, 32'hD, 32'd5);

    #2;
    checkM(bubble(), "reset");
    chk("reset_busy", 32'(BusyE), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      applyVec(vecs[i], i);
      #2;
      chk($sformatf("v%0d_pcsrc", i), 32'(PCSrcE), 32'(vecs[i].expPcSrc));
      chk($sformatf("v%0d_target", i), PCTargetE, vecs[i].expTgt);
      chk($sformatf("v%0d_busy", i), 32'(BusyE), 32'd0);
      @(posedge clk); #1;
      popCheck($sformatf("v%0d", i));
    end

    doMul(32'h0000FFFF, 32'h00010001, 5'd9, 32'hFFFFFFFF, "mul1");
    doMul(32'h80000000, 32'd2, 5'd10, 32'd0, "mul2");

    // Flush in RUN cycle 10: start edge plus ten RUN edges.
    driveOp(4'd10, 32'd3, 32'd5, 5'd11);
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
    end
    chk("flush_pre_busy", 32'(BusyE), 32'd1);
    FlushE = 1'b1;
    BranchE = 1'b1;
    #1;
    chk("flush_busy", 32'(BusyE), 32'd0);
    chk("flush_pcsrc", 32'(PCSrcE), 32'd0);
    sb.push_back(bubble());
    @(posedge clk); #1;
    popCheck("flush_m");
    driveOp(4'd0, 32'd4, 32'd5, 5'd3);
    sb.push_back(opExp(5'd3, 32'd9, 32'd5));
    #1;
    chk("flush_idle_busy", 32'(BusyE), 32'd0);
    @(posedge clk); #1;
    popCheck("post_flush_add");

    // Asynchronous reset with a live result in M.
    driveOp(4'd0, 32'd2, 32'd3, 5'd4);
    sb.push_back(opExp(5'd4, 32'd5, 32'd3));
    @(posedge clk); #1;
    popCheck("pre_rst_add");
    #2;
    rst = 1'b1;
    #1;
    checkM(bubble(), "rst_async");
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset during RUN abandons the multiply.
    driveOp(4'd10, 32'h0000FFFF, 32'h00010001, 5'd12);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_run_busy", 32'(BusyE), 32'd1);
    #2;
    rst = 1'b1;
    ALUControlE = 4'd0;
    #1;
    chk("rst_fsm_idle", 32'(BusyE), 32'd0);
    checkM(bubble(), "rst_run");
    rst = 1'b0;
    @(posedge clk); #1;
    doMul(32'h0000FFFF, 32'h00010001, 5'd13, 32'hFFFFFFFF, "mul_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
